matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter N, default 5, matrix dimension (N x N).
REQ-002 Parameter DATA_WIDTH, default 8, element width.
REQ-003 Parameter TIMEOUT, default 64, maximum WAIT-state cycles before abort.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  upstream element valid.
REQ-007 s_ready  output  1  loader accepts an element this cycle.
REQ-008 s_data  input  DATA_WIDTH  element value, row-major order: all of A, then all of B.
REQ-009 a  output  [0:N-1][0:N-1] x DATA_WIDTH  matrix A presented to the array.
REQ-010 valid_bit_a_in  output  [0:N-1][0:N-1] x 1  per-element valid for A.
REQ-011 b  output  [0:N-1][0:N-1] x DATA_WIDTH  matrix B presented to the array.
REQ-012 valid_bit_b_in  output  [0:N-1][0:N-1] x 1  per-element valid for B.
REQ-013 array_done  input  1  the array's valid_bit_out; marks the result as complete.
REQ-014 busy  output  1  high in DRIVE and WAIT.
REQ-015 timeout_err  output  1  sticky; set on WAIT timeout; cleared only by reset.

Function
REQ-016 States SHALL be LOAD_A, LOAD_B, DRIVE and WAIT.
REQ-017 LOAD_A: s_ready=1; each handshake (s_valid & s_ready) writes A buffer [idx/N][idx%N]; idx increments 0..N*N-1.
REQ-018 The handshake with idx=N*N-1 in LOAD_A SHALL clear idx and enter LOAD_B next cycle.
REQ-019 LOAD_B behaves as LOAD_A, filling the B buffer.
REQ-020 The last LOAD_B handshake SHALL enter DRIVE next cycle.
REQ-021 Cycles with s_valid=0 SHALL leave idx and buffers unchanged; gaps of any length are legal.
REQ-022 DRIVE: s_ready=0; a/b equal the buffers; all valid bits=1 for exactly N consecutive cycles, counted by a drive counter.
REQ-023 After N DRIVE cycles: enter WAIT; a, b and all valid bits = 0.
REQ-024 Outside DRIVE, a, b and all valid bits SHALL be 0.
REQ-025 WAIT: s_ready=0; array_done=1 returns to LOAD_A next cycle.
REQ-026 If array_done stays low for TIMEOUT cycles in WAIT, the block SHALL set timeout_err and return to LOAD_A.
REQ-027 array_done outside WAIT SHALL be ignored.
REQ-028 array_done and timeout expiring in the same cycle: completion wins; timeout_err is not set.
REQ-029 s_valid outside LOAD_A/LOAD_B: no effect, no data captured.
REQ-030 Latency: first DRIVE cycle is the cycle after the final B handshake; idle cycles between matrices = 0.
REQ-031 All outputs SHALL be registered or decoded only from state; no combinational path from s_valid to s_ready.

Reset
REQ-032 rst_n low SHALL immediately force state LOAD_A, idx=0, drive and timeout counters=0, timeout_err=0, busy=0, a/b=0, all valid bits=0, s_ready=0 while rst_n is low.
REQ-033 Buffer contents need not reset; they are never visible before a full reload.
REQ-034 Reset during any state SHALL abandon the partial frame; loading restarts at A[0][0] after release.

Structure
REQ-035 The shared package SHALL hold: the state enum type, the defaults for N and DATA_WIDTH, and the element typedef.
REQ-036 One sub-module, matrix_buffer, SHALL hold the N x N register array with write-enable and row/column index; it is instantiated twice (A, B).
REQ-037 The output of matrix_loader connects port-for-port to the systolic array top's a/valid_bit_a_in/b/valid_bit_b_in inputs.

Verification
REQ-038 Stream 1..25 then 25..1, s_valid always high, N=5 -> a[0]={1,2,3,4,5}, a[4]={21..25}, b[0]={25..21}; all valid bits=1 for exactly 5 cycles starting the cycle after beat 50.
REQ-039 Same stream with s_valid toggling 1/0 each cycle -> identical matrices; DRIVE starts the cycle after the 50th accepted beat.
REQ-040 s_valid held high during DRIVE/WAIT with value 99 -> s_ready=0; 99 never appears in a or b; next frame starts at A[0][0].
REQ-041 array_done never asserted, TIMEOUT=64 -> timeout_err=1 after 64 WAIT cycles; state returns to LOAD_A; s_ready=1.
REQ-042 Reset pulse after 12 A beats, then a fresh 50-beat stream -> matrices match the fresh stream exactly.
REQ-043 array_done pulsed during LOAD_B -> ignored; DRIVE still lasts 5 cycles; WAIT then exits on the next array_done.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// rtl/matrix_loader_pkg.sv - shared types and defaults for the matrix loader
package matrix_loader_pkg;

  localparam int DEF_N          = 5;
  localparam int DEF_DATA_WIDTH = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] elem_t;

  // Encodings are fixed so legacy state dumps keep decoding the same way.
  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_DRIVE  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_loader_buffer.sv
// rtl/matrix_loader_buffer.sv - N x N element register array with indexed write
module matrix_buffer
  import matrix_loader_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                   clk,
  input  logic                                   we,
  input  logic [IW-1:0]                          row,
  input  logic [IW-1:0]                          col,
  input  logic [DATA_WIDTH-1:0]                  din,
  output logic [0:N-1][0:N-1][DATA_WIDTH-1:0]    mem
);

  // Write one element per enabled cycle; contents are not reset because a full
  // reload always precedes the next time they are presented.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[row][col] <= din;
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - streams two N x N matrices in and presents them to the array
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  output logic [0:N-1][0:N-1][DATA_WIDTH-1:0] a,
  output logic [0:N-1][0:N-1]                 valid_bit_a_in,
  output logic [0:N-1][0:N-1][DATA_WIDTH-1:0] b,
  output logic [0:N-1][0:N-1]                 valid_bit_b_in,
  input  logic                                array_done,
  output logic                                busy,
  output logic                                timeout_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   row_q, col_q;
  logic [IW-1:0]   drive_q;
  logic [TW-1:0]   wait_q;
  logic            ready_q;
  logic            err_q;

  logic [0:N-1][0:N-1][DATA_WIDTH-1:0] buf_a, buf_b;

  logic hs, we_a, we_b, last_elem, last_col, drive_last, timeout_fire;

  // ready_q is a flop, so the handshake never loops back through s_ready.
  assign hs           = s_valid & ready_q;
  assign we_a         = hs & (state_q == ST_LOAD_A);
  assign we_b         = hs & (state_q == ST_LOAD_B);
  assign last_col     = (col_q == IW'(N - 1));
  assign last_elem    = last_col & (row_q == IW'(N - 1));
  assign drive_last   = (drive_q == IW'(N - 1));
  assign timeout_fire = (state_q == ST_WAIT) & ~array_done & (wait_q == TW'(TIMEOUT - 1));

  matrix_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_buf_a (
    .clk (clk),
    .we  (we_a),
    .row (row_q),
    .col (col_q),
    .din (s_data),
    .mem (buf_a)
  );

  matrix_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_buf_b (
    .clk (clk),
    .we  (we_b),
    .row (row_q),
    .col (col_q),
    .din (s_data),
    .mem (buf_b)
  );

  // Next-state selection; array_done only matters while waiting and beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD_A: if (we_a && last_elem) state_d = ST_LOAD_B;
      ST_LOAD_B: if (we_b && last_elem) state_d = ST_DRIVE;
      ST_DRIVE:  if (drive_last)        state_d = ST_WAIT;
      ST_WAIT:   if (array_done || timeout_fire) state_d = ST_LOAD_A;
      default:   state_d = ST_LOAD_A;
    endcase
  end

  // State, load index, drive/timeout counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD_A;
      row_q   <= '0;
      col_q   <= '0;
      drive_q <= '0;
      wait_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);

      if (we_a || we_b) begin
        if (last_elem) begin
          row_q <= '0;
          col_q <= '0;
        end else if (last_col) begin
          row_q <= row_q + IW'(1);
          col_q <= '0;
        end else begin
          col_q <= col_q + IW'(1);
        end
      end

      if (state_q == ST_DRIVE) begin
        drive_q <= drive_last ? '0 : drive_q + IW'(1);
      end else begin
        drive_q <= '0;
      end

      if (state_q == ST_WAIT && !array_done && !timeout_fire) begin
        wait_q <= wait_q + TW'(1);
      end else begin
        wait_q <= '0;
      end

      if (timeout_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  // Matrices and valid bits are only visible during DRIVE, zero otherwise.
  always_comb begin
    a              = '0;
    b              = '0;
    valid_bit_a_in = '0;
    valid_bit_b_in = '0;
    if (state_q == ST_DRIVE) begin
      a              = buf_a;
      b              = buf_b;
      valid_bit_a_in = '1;
      valid_bit_b_in = '1;
    end
  end

  assign s_ready     = ready_q;
  assign busy        = (state_q == ST_DRIVE) || (state_q == ST_WAIT);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - scoreboard bench for matrix_loader
module tb_matrix_loader;

  localparam int N   = 5;
  localparam int DW  = 8;
  localparam int TO  = 64;
  localparam int NN  = N * N;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         s_valid = 1'b0;
  logic                         s_ready;
  logic [DW-1:0]                s_data = '0;
  logic [0:N-1][0:N-1][DW-1:0]  a, b;
  logic [0:N-1][0:N-1]          valid_bit_a_in, valid_bit_b_in;
  logic                         array_done = 1'b0;
  logic                         busy;
  logic                         timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_hs = 0;

  logic [DW-1:0] fv [0:2*NN-1];
  logic [DW-1:0] exp_data [$];
  int            exp_start [$];

  matrix_loader #(.N(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .a              (a),
    .valid_bit_a_in (valid_bit_a_in),
    .b              (b),
    .valid_bit_b_in (valid_bit_b_in),
    .array_done     (array_done),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One beat; called at a negedge, returns at the negedge after the handshake.
  task automatic send_beat(input logic [DW-1:0] v);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = v;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      check("beat_accept_timeout", 256'(s_ready), 256'(1));
    end else begin
      last_hs = cyc;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: toggle 1/0, 2: random gaps, 3: random gaps + array_done during B.
  task automatic send_frame(input int mode);
    for (int i = 0; i < 2 * NN; i++) begin
      if (mode == 3 && i == NN + 7) begin
        array_done = 1'b1;
        @(negedge clk);
        array_done = 1'b0;
        check("ready_after_done_in_b", 256'(s_ready), 256'(1));
      end
      send_beat(fv[i]);
      if (i == 2 * NN - 1) begin
        for (int k = 0; k < 2 * NN; k++) exp_data.push_back(fv[k]);
        exp_start.push_back(last_hs + 1);
      end else if (mode == 1) begin
        @(negedge clk);
      end else if (mode >= 2) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2 * NN; i++) fv[i] = DW'($urandom_range(0, 255));
  endtask

  task automatic pulse_done();
    array_done = 1'b1;
    @(negedge clk);
    array_done = 1'b0;
  endtask

  // Monitor: pops one expected frame at the start of each drive window.
  initial begin
    int run;
    int have;
    logic [DW-1:0] vals [0:2*NN-1];
    logic [0:N-1][0:N-1][DW-1:0] ea, eb;
    run = 0;
    have = 0;
    forever begin
      @(negedge clk);
      #1;
      if ((|valid_bit_a_in) || (|valid_bit_b_in)) begin
        if (run == 0) begin
          if (exp_start.size() == 0) begin
            check("unexpected_drive", 256'(1), 256'(0));
          end else begin
            check("drive_start_cycle", 256'(cyc), 256'(exp_start.pop_front()));
            for (int i = 0; i < 2 * NN; i++) vals[i] = exp_data.pop_front();
            have = 1;
          end
        end
        run++;
        check("valid_a_all", 256'(valid_bit_a_in), 256'({NN{1'b1}}));
        check("valid_b_all", 256'(valid_bit_b_in), 256'({NN{1'b1}}));
        if (have != 0) begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
              ea[r][c] = vals[r * N + c];
              eb[r][c] = vals[NN + r * N + c];
            end
          check("matrix_a", 256'(a), 256'(ea));
          check("matrix_b", 256'(b), 256'(eb));
        end
      end else begin
        if (run != 0) begin
          check("drive_len", 256'(run), 256'(N));
          run = 0;
          have = 0;
        end
        check("idle_a_zero", 256'(a), 256'(0));
        check("idle_b_zero", 256'(b), 256'(0));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_s_ready", 256'(s_ready), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_err", 256'(timeout_err), 256'(0));
    check("rst_valid", 256'(valid_bit_a_in), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1..25 then 25..1 back-to-back; 99 held during DRIVE/WAIT
    for (int i = 0; i < NN; i++) begin
      fv[i]      = DW'(i + 1);
      fv[NN + i] = DW'(NN - i);
    end
    send_frame(0);
    s_valid = 1'b1;
    s_data  = 8'd99;
    for (int k = 0; k < 12; k++) begin
      check("ready_low_busy", 256'(s_ready), 256'(0));
      check("busy_high", 256'(busy), 256'(1));
      @(negedge clk);
    end
    s_valid = 1'b0;
    pulse_done();
    check("ready_after_done", 256'(s_ready), 256'(1));
    check("busy_after_done", 256'(busy), 256'(0));

    // Same stream with s_valid toggling
    send_frame(1);
    repeat (8) @(negedge clk);
    pulse_done();

    // Random data with random gaps
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame(2);
      repeat ($urandom_range(6, 20)) @(negedge clk);
      pulse_done();
    end

    // array_done during LOAD_B is ignored; WAIT exits on the next one
    fill_random();
    send_frame(3);
    repeat (10) @(negedge clk);
    check("wait_busy", 256'(busy), 256'(1));
    pulse_done();
    check("wait_exit", 256'(busy), 256'(0));

    // Completion and timeout in the same cycle: completion wins
    fill_random();
    send_frame(0);
    repeat (TO + 4) @(negedge clk);
    check("tie_busy", 256'(busy), 256'(1));
    pulse_done();
    check("tie_err", 256'(timeout_err), 256'(0));
    check("tie_ready", 256'(s_ready), 256'(1));

    // Timeout with array_done never asserted
    fill_random();
    send_frame(0);
    repeat (TO + 4) @(negedge clk);
    check("pre_to_err", 256'(timeout_err), 256'(0));
    check("pre_to_busy", 256'(busy), 256'(1));
    @(negedge clk);
    check("to_err", 256'(timeout_err), 256'(1));
    check("to_busy", 256'(busy), 256'(0));
    check("to_ready", 256'(s_ready), 256'(1));

    // Reset after 12 A beats, then a fresh frame
    for (int i = 0; i < 12; i++) send_beat(DW'($urandom_range(0, 255)));
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 256'(s_ready), 256'(0));
    check("midrst_err", 256'(timeout_err), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    send_frame(2);
    repeat (10) @(negedge clk);
    pulse_done();

    repeat (10) @(negedge clk);
    check("frames_drained", 256'(exp_start.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
